// File: rtl/laser_point_feeder_pkg.sv
// laser_point_feeder_pkg: frame geometry, point type and stream FSM states shared by the feeder and the core
package laser_point_feeder_pkg;
  localparam int NPTS = 40;
  localparam int CW = 4;
  localparam int IW = $clog2(NPTS);
  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } point_t;
  typedef enum logic [1:0] {HOLD, STREAM, WAIT_DONE} state_e;
endpackage

// File: rtl/laser_pingpong_buf.sv
// laser_pingpong_buf: two NPTS-point banks with full flags, host write side and a registered read port
module laser_pingpong_buf
  import laser_point_feeder_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_valid,
  output logic          o_wr_ready,
  input  point_t        i_wr_pt,
  input  logic          i_rd_bank,
  input  logic [IW-1:0] i_rd_idx,
  output point_t        o_rd_pt,
  input  logic          i_clr,
  input  logic          i_clr_bank,
  output logic [1:0]    o_full
);
  point_t        r_mem [2][NPTS];
  point_t        r_rd_pt;
  logic [1:0]    r_full;
  logic          r_wr_bank;
  logic [IW-1:0] r_wr_idx;
  logic          w_acc;
  logic          w_last;
  assign o_wr_ready = !r_full[r_wr_bank];
  assign w_acc = i_wr_valid && o_wr_ready;
  assign w_last = r_wr_idx == IW'(NPTS - 1);
  assign o_full = r_full;
  assign o_rd_pt = r_rd_pt;
  always_ff @(posedge i_clk)
    if (w_acc) r_mem[r_wr_bank][r_wr_idx] <= i_wr_pt;
  // set and clear always hit different banks, so both updates can land in one cycle
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_full <= '0;
      r_wr_bank <= 1'b0;
      r_wr_idx <= '0;
      r_rd_pt <= '0;
    end else begin
      r_rd_pt <= r_mem[i_rd_bank][i_rd_idx];
      if (i_clr) r_full[i_clr_bank] <= 1'b0;
      if (w_acc) begin
        r_wr_idx <= w_last ? '0 : r_wr_idx + 1'b1;
        if (w_last) begin
          r_full[r_wr_bank] <= 1'b1;
          r_wr_bank <= !r_wr_bank;
        end
      end
    end
endmodule

// File: rtl/laser_point_feeder.sv
// laser_point_feeder: ping-pong buffers host points and streams one frame per core run, re-arming on DONE
module laser_point_feeder
  import laser_point_feeder_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [CW-1:0] i_in_x,
  input  logic [CW-1:0] i_in_y,
  output logic          o_core_rst,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  input  logic          i_done,
  output logic [7:0]    o_frame_cnt
);
  state_e        r_state;
  state_e        w_nxt_state;
  logic          r_rd_bank;
  logic          w_nxt_bank;
  logic [IW-1:0] r_rd_idx;
  logic [IW-1:0] w_nxt_idx;
  logic [1:0]    w_full;
  point_t        w_rd_pt;
  point_t        w_in_pt;
  logic          w_ld;
  logic          w_fin;
  assign w_in_pt = '{x: i_in_x, y: i_in_y};
  assign o_core_rst = r_state == HOLD;
  assign w_fin = r_state == WAIT_DONE && i_done;
  assign w_ld = (r_state == HOLD && w_full[r_rd_bank]) || (r_state == STREAM && r_rd_idx != '0);
  // the read port is addressed with next-cycle pointers so its registered data is ready when X/Y load
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_bank = r_rd_bank ^ w_fin;
    w_nxt_idx = w_ld ? (r_rd_idx == IW'(NPTS - 1) ? '0 : r_rd_idx + 1'b1) : '0;
    case (r_state)
      HOLD:      w_nxt_state = w_full[r_rd_bank] ? STREAM : HOLD;
      STREAM:    w_nxt_state = r_rd_idx == '0 ? WAIT_DONE : STREAM;
      WAIT_DONE: w_nxt_state = i_done ? HOLD : WAIT_DONE;
      default:   w_nxt_state = HOLD;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= HOLD;
      r_rd_bank <= 1'b0;
      r_rd_idx <= '0;
      o_x <= '0;
      o_y <= '0;
      o_frame_cnt <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_rd_bank <= w_nxt_bank;
      r_rd_idx <= w_nxt_idx;
      if (w_ld) begin
        o_x <= w_rd_pt.x;
        o_y <= w_rd_pt.y;
      end
      if (w_fin) o_frame_cnt <= o_frame_cnt + 8'd1;
    end
  laser_pingpong_buf u_buf (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wr_valid (i_in_valid),
    .o_wr_ready (o_in_ready),
    .i_wr_pt    (w_in_pt),
    .i_rd_bank  (w_nxt_bank),
    .i_rd_idx   (w_nxt_idx),
    .o_rd_pt    (w_rd_pt),
    .i_clr      (w_fin),
    .i_clr_bank (r_rd_bank),
    .o_full     (w_full)
  );
endmodule
